iter_multdiv: RTL and testbench
===============================

ITER_MULTDIV -- requirements
Module: iter_multdiv

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 clock  input  1  master clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_operandA  input  32  signed two's-complement multiplicand or dividend.
REQ-005 data_operandB  input  32  signed two's-complement multiplier or divisor.
REQ-006 ctrl_MULT  input  1  single-cycle start pulse for a multiply, driven by the execute stage.
REQ-007 ctrl_DIV  input  1  single-cycle start pulse for a divide.
REQ-008 data_result  output  32  registered signed result.
REQ-009 data_exception  output  1  registered exception flag, valid with data_result.
REQ-010 data_resultRDY  output  1  registered one-cycle completion strobe.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-012 In IDLE, a rising edge with ctrl_MULT or ctrl_DIV high SHALL capture both operands and the operation type, clear the 5-bit iteration counter, and enter BUSY.
REQ-013 If ctrl_MULT and ctrl_DIV are both high at the start edge, the operation SHALL be a multiply.
REQ-014 ctrl_MULT and ctrl_DIV SHALL be ignored in BUSY and DONE; operand inputs SHALL be ignored after the start edge.
REQ-015 BUSY SHALL perform exactly 32 iterations, one per edge, on the operand magnitudes: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 After iteration 32, the FSM SHALL enter DONE and load data_result and data_exception.
REQ-017 data_resultRDY SHALL be high for exactly one period, starting at the 33rd rising edge after the start edge; the FSM SHALL then return to IDLE.
REQ-018 A new start SHALL be accepted on the edge that leaves DONE if a ctrl input is high; back-to-back throughput SHALL be one operation per 34 cycles.
REQ-019 data_result and data_exception SHALL hold their values until the next operation completes.
REQ-020 Multiply: form the 64-bit unsigned product of the magnitudes (|-2^31| = 2^31), negate it if the operand signs differ, and output the low 32 bits.
REQ-021 Multiply: data_exception SHALL be 1 iff bits 63..31 of the signed 64-bit product are not all equal.
REQ-022 Divide: the quotient SHALL truncate toward zero, with its sign equal to sign(A) XOR sign(B); the remainder SHALL be discarded.
REQ-023 Divide by zero: data_result = 0 and data_exception = 1, with the same 33-cycle latency.
REQ-024 Divide 0x80000000 by 0xFFFFFFFF: data_result = 0 and data_exception = 1.
REQ-025 All other divides SHALL produce data_exception = 0.
REQ-026 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-027 While reset is high at an edge, the FSM SHALL go to IDLE, the counter SHALL go to 0, and data_result, data_exception and data_resultRDY SHALL go to 0.
REQ-028 Reset SHALL override any simultaneous start pulse.
REQ-029 Reset during BUSY or DONE SHALL abort the operation; no data_resultRDY for the aborted operation SHALL ever appear.
REQ-030 On the first edge after reset deasserts, the block SHALL be ready to accept a start.

Verification
REQ-031 MULT pulse with A = 7, B = -3 -> at edge 33: RDY = 1 for one cycle, result = 0xFFFFFFEB, exception = 0; RDY = 0 at edge 34.
REQ-032 MULT with A = 0x00010000, B = 0x00010000 -> result = 0x00000000, exception = 1; MULT with A = 0x80000000, B = 1 -> result = 0x80000000, exception = 0.
REQ-033 DIV with A = -7, B = 2 -> result = 0xFFFFFFFD, exception = 0; DIV with A = 100, B = 7 -> result = 14.
REQ-034 DIV with A = 5, B = 0 -> result = 0, exception = 1 at edge 33; DIV with A = 0x80000000, B = 0xFFFFFFFF -> result = 0, exception = 1.
REQ-035 Start a MULT, pulse DIV at cycle 10, and change the operands at cycle 5 -> exactly one RDY at edge 33 carrying the original multiply result; no second RDY.
REQ-036 Start a DIV and assert reset at cycle 12 -> all outputs 0 and no RDY within 40 cycles; a MULT 3 × 4 issued after reset -> result = 12 exactly 33 edges after its start.

Source files
------------

// File: rtl/iter_multdiv.sv
// -----------------------------------------------------------------------------
// iter_multdiv
//
// Iterative signed 32-bit multiplier / divider. A start pulse captures both
// operands and the operation. The core then runs 32 shift-add (multiply) or
// restoring shift-subtract (divide) steps on the operand magnitudes, one per
// clock. A finishing edge applies the result sign, detects exceptions and
// registers the outputs. The result then sits in DONE for one cycle with
// data_resultRDY high.
//
// Timing, counting the start edge as edge 0:
//   edges 1..32  iterations
//   edge 33      result, exception and RDY registered; FSM enters DONE
//   edge 34      FSM leaves DONE; a start pulse on this edge is accepted
// This gives one operation every 34 cycles when operations run back to back.
//
// Ports
//   clock           in   master clock, rising edge
//   reset           in   synchronous, active-high reset
//   data_operandA   in   32  signed multiplicand / dividend
//   data_operandB   in   32  signed multiplier / divisor
//   ctrl_MULT       in   1   start a multiply (wins if ctrl_DIV is also high)
//   ctrl_DIV        in   1   start a divide
//   data_result     out  32  registered signed result, held until next completion
//   data_exception  out  1   registered overflow / divide-by-zero flag
//   data_resultRDY  out  1   one-cycle completion strobe
// -----------------------------------------------------------------------------
module iter_multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // control
    logic [4:0] cnt;
    logic       iter_end;      // set once the 32nd iteration has been done
    logic       start;
    logic       iterate;
    logic       finish;

    // datapath (no reset: every field is loaded on start before it is used)
    logic              op_mul;
    logic              res_neg;
    logic [DATA_W-1:0] opnd;   // multiplicand (mul) or divisor (div) magnitude
    logic [DATA_W-1:0] upper;  // product high half / partial remainder
    logic [DATA_W-1:0] lower;  // product low half + multiplier / quotient + dividend

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_sub;

    logic [DATA_W-1:0] fin_result;
    logic              fin_exc;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    // |v|; the most negative value maps to 2^31, which is exact as unsigned.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign64(input logic [2*DATA_W-1:0] v,
                                                         input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    // The signed product fits in 32 bits only if bits 63..31 are one sign run.
    function automatic logic mul_overflow(input logic [2*DATA_W-1:0] p);
        return !((&p[2*DATA_W-1:DATA_W-1]) || !(|p[2*DATA_W-1:DATA_W-1]));
    endfunction

    // Saturating divide finish: returns {exception, result}.
    // A positive quotient with bit 31 set can only be 2^31, which comes from
    // 0x80000000 / -1 and is not representable.
    function automatic logic [DATA_W:0] div_finish(input logic [DATA_W-1:0] q,
                                                   input logic neg,
                                                   input logic div_zero);
        logic [DATA_W-1:0] q_signed;
        q_signed = neg ? (~q + 32'd1) : q;
        if (div_zero)
            return {1'b1, {DATA_W{1'b0}}};
        else if (!neg && q[DATA_W-1])
            return {1'b1, {DATA_W{1'b0}}};
        else
            return {1'b0, q_signed};
    endfunction

    // -------------------------------------------------------------------------
    // FSM next state and step controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        iterate   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                start = ctrl_MULT || ctrl_DIV;
                if (start)
                    state_nxt = BUSY;
            end
            BUSY: begin
                if (iter_end) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    iterate = 1'b1;
                end
            end
            DONE: begin
                // Leaving DONE doubles as the earliest start edge.
                start     = ctrl_MULT || ctrl_DIV;
                state_nxt = start ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Iteration step logic
    // -------------------------------------------------------------------------
    always_comb begin
        // shift-add: add multiplicand when the current multiplier bit is set
        mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
        // restoring divide: bring in the next dividend bit and trial-subtract
        div_shift = {upper, lower[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // when div_ge the true difference is below the divisor, so 32 bits hold it
        div_sub   = div_shift[DATA_W-1:0] - opnd;
    end

    // -------------------------------------------------------------------------
    // Result finishing (from registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W:0]     dres;
        prod = apply_sign64({upper, lower}, res_neg);
        dres = div_finish(lower, res_neg, (opnd == '0));
        if (op_mul) begin
            fin_result = prod[DATA_W-1:0];
            fin_exc    = mul_overflow(prod);
        end else begin
            fin_result = dres[DATA_W-1:0];
            fin_exc    = dres[DATA_W];
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            iter_end       <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_nxt;
            data_resultRDY <= finish;
            if (start) begin
                cnt      <= 5'd0;
                iter_end <= 1'b0;
            end else if (iterate) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31)
                    iter_end <= 1'b1;
            end
            if (finish) begin
                data_result    <= fin_result;
                data_exception <= fin_exc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (start) begin
            op_mul  <= ctrl_MULT;
            res_neg <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            upper   <= '0;
            if (ctrl_MULT) begin
                opnd  <= magnitude(data_operandA);
                lower <= magnitude(data_operandB);
            end else begin
                opnd  <= magnitude(data_operandB);
                lower <= magnitude(data_operandA);
            end
        end else if (iterate) begin
            if (op_mul) begin
                upper <= mul_sum[DATA_W:1];
                lower <= {mul_sum[0], lower[DATA_W-1:1]};
            end else begin
                upper <= div_ge ? div_sub : div_shift[DATA_W-1:0];
                lower <= {lower[DATA_W-2:0], div_ge};
            end
        end
    end

endmodule

// File: tb/tb_iter_multdiv.sv
// -----------------------------------------------------------------------------
// tb_iter_multdiv
//
// Directed bench for iter_multdiv. Each vector carries a hand-computed
// expected result. Edges are counted from the start edge (edge 0), and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_iter_multdiv;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    iter_multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation: start pulse, then watch 36 edges for exactly one RDY at
    // edge 33. Operands are scrambled right after the start edge. reset is
    // released on the same negedge that raises the start pulse.
    task automatic run_op(input string tag, input logic mul,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e);
        int          lat;
        int          nrdy;
        logic [31:0] r;
        logic        e;
        lat = 0; nrdy = 0; r = '0; e = 1'b0;
        @(negedge clock);
        reset         = 1'b0;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = mul;
        ctrl_DIV      = !mul;
        @(posedge clock);
        for (int i = 1; i <= 36; i++) begin
            @(negedge clock);
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            data_operandA = ~a;
            data_operandB = ~b;
            @(posedge clock); #1;
            if (data_resultRDY) begin
                nrdy++;
                if (lat == 0) begin
                    lat = i;
                    r   = data_result;
                    e   = data_exception;
                end
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_rdy_count"}, 64'(nrdy), 64'd1);
        check({tag, "_result"}, 64'(r), 64'(exp_r));
        check({tag, "_exception"}, 64'(e), 64'(exp_e));
    endtask

    initial begin
        int          lat;
        int          nrdy;
        int          bad;
        int          lat2;
        logic [31:0] r;
        logic [31:0] r2;
        logic [31:0] held;
        logic        e;

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_exception", 64'(data_exception), 64'd0);
        check("reset_rdy", 64'(data_resultRDY), 64'd0);

        // Start pulse while reset is high must be ignored; the next start
        // comes on the first edge after reset falls (-1 * -1 = 1).
        @(negedge clock);
        data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        check("reset_override_rdy", 64'(data_resultRDY), 64'd0);
        run_op("mul_after_reset", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);

        // ---------------- multiply vectors ----------------
        run_op("mul_7_m3",     1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("mul_2p16_sq",  1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
        run_op("mul_min_x1",   1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0);
        run_op("mul_max_sq",   1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1);

        // ---------------- divide vectors ----------------
        run_op("div_m7_2",     1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("div_100_7",    1'b0, 32'd100,      32'd7,        32'd14,       1'b0);
        run_op("div_m100_m7",  1'b0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0);
        run_op("div_by_zero",  1'b0, 32'd5,        32'd0,        32'd0,        1'b1);
        run_op("div_min_m1",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
        run_op("div_min_1",    1'b0, 32'h80000000, 32'd1,        32'h80000000, 1'b0);

        // -------- ctrl and operand changes during BUSY are ignored --------
        lat = 0; nrdy = 0; r = '0; e = 1'b0;
        @(negedge clock);
        data_operandA = 32'd1000; data_operandB = 32'hFFFFFFFB; ctrl_MULT = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            ctrl_DIV  = (i == 10);
            if (i == 5) begin
                data_operandA = 32'd3; data_operandB = 32'd3;
            end
            @(posedge clock); #1;
            if (data_resultRDY) begin
                nrdy++;
                if (lat == 0) begin
                    lat = i; r = data_result; e = data_exception;
                end
            end
        end
        check("ignore_busy_latency", 64'(lat), 64'd33);
        check("ignore_busy_rdy_count", 64'(nrdy), 64'd1);
        check("ignore_busy_result", 64'(r), 64'hFFFFEC78);
        check("ignore_busy_exception", 64'(e), 64'd0);

        // -------- back-to-back: ctrl held high, second start at edge 34 --------
        lat = 0; lat2 = 0; nrdy = 0; r = '0; r2 = '0; held = '0;
        @(negedge clock);
        data_operandA = 32'd2; data_operandB = 32'd3; ctrl_MULT = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 70; i++) begin
            @(negedge clock);
            ctrl_MULT = (i <= 34);
            if (i == 20) begin
                data_operandA = 32'd5; data_operandB = 32'd6;
            end
            @(posedge clock); #1;
            if (i == 50) held = data_result;
            if (data_resultRDY) begin
                nrdy++;
                if (lat == 0) begin
                    lat = i; r = data_result;
                end else if (lat2 == 0) begin
                    lat2 = i; r2 = data_result;
                end
            end
        end
        ctrl_MULT = 1'b0;
        check("b2b_first_latency", 64'(lat), 64'd33);
        check("b2b_first_result", 64'(r), 64'd6);
        check("b2b_hold_result", 64'(held), 64'd6);
        check("b2b_second_edge", 64'(lat2), 64'd67);
        check("b2b_second_result", 64'(r2), 64'd30);
        check("b2b_rdy_count", 64'(nrdy), 64'd2);

        // -------- reset during BUSY aborts the divide --------
        @(negedge clock);
        data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        @(posedge clock);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
            reset    = (i == 12);
            @(posedge clock);
        end
        #1;
        check("abort_result", 64'(data_result), 64'd0);
        check("abort_exception", 64'(data_exception), 64'd0);
        check("abort_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        nrdy = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) nrdy++;
            if (data_result != 32'd0 || data_exception) bad++;
        end
        check("abort_no_rdy", 64'(nrdy), 64'd0);
        check("abort_outputs_zero", 64'(bad), 64'd0);
        run_op("mul_3_4", 1'b1, 32'd3, 32'd4, 32'd12, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
